multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum wait cycles for MemReady per memory access before fault.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 OP  input  6  opcode field of the instruction register, sampled in DECODE.
REQ-005 MemReady  input  1  memory handshake; access completes in the cycle MemReady=1 while MemRead or MemWrite=1.
REQ-006 PCWrite  output  1  unconditional PC load.
REQ-007 BranchEn  output  1  conditional PC load, qualified by ALU zero and BranchType.
REQ-008 BranchType  output  1  1 = beq, 0 = bne.
REQ-009 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 MemRead  output  1  memory read strobe.
REQ-011 MemWrite  output  1  memory write strobe.
REQ-012 IRWrite  output  1  instruction register load.
REQ-013 MemtoReg  output  1  write-back source: 1 = memory data register.
REQ-014 RegDst  output  1  destination: 1 = rd, 0 = rt.
REQ-015 RegWrite  output  1  register file write enable.
REQ-016 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-017 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-018 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-019 ALUOp  output  3  111 R-type, 100 add, 101 or, 110 and, 001 sub, 000 lui.
REQ-020 State  output  4  current state encoding, for debug.
REQ-021 Fault  output  1  one-cycle pulse on illegal opcode or memory timeout.

Function
REQ-022 States (encoding): START 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, I_EXEC 8, ALU_WB 9, BRANCH 10, JUMP 11; unused encodings go to FETCH next cycle.
REQ-023 Outputs are Moore-decoded from State, except IRWrite/PCWrite in FETCH, which are qualified by MemReady; unlisted outputs are 0.
REQ-024 START: all outputs 0; next FETCH.
REQ-025 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00; with MemReady=1: IRWrite=1, PCWrite=1, next DECODE; otherwise stay.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100; next by OP: 00->R_EXEC, 08/0C/0D/0F->I_EXEC, 23/2B->MEM_ADDR, 04/05->BRANCH; any other OP pulses Fault, next FETCH.
REQ-027 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next ALU_WB with RegDst=1.
REQ-028 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=100/110/101/000 for ADDI/ANDI/ORI/LUI; next ALU_WB with RegDst=0.
REQ-029 ALU_WB: RegWrite=1, MemtoReg=0, RegDst per REQ-027/REQ-028, ALUOp held; next FETCH. The opcode class is latched in DECODE.
REQ-030 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100; next MEM_READ for 23, MEM_WRITE for 2B.
REQ-031 MEM_READ: MemRead=1, IorD=1; wait for MemReady, then MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-032 MEM_WRITE: MemWrite=1, IorD=1; wait for MemReady, then FETCH.
REQ-033 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, BranchEn=1, BranchType=1 for 04 and 0 for 05; next FETCH.
REQ-034 Wait counter: cleared on entry to FETCH, MEM_READ and MEM_WRITE, incremented each cycle MemReady=0 in those states; when it reaches WAIT_MAX with MemReady still 0, Fault pulses and next is FETCH. MemReady=1 in the same cycle takes priority (access completes).
REQ-035 Instruction latency: R/I-type 4 cycles, lw 5, sw 4, branch 3, assuming MemReady=1 with zero wait cycles.

Reset
REQ-036 reset=0 asynchronously forces START, clears the counter and opclass latch, and holds all outputs at 0 (State=0), including mid-access.
REQ-037 After reset release, first FETCH occurs on the second rising edge.

Configuration
REQ-038 MULTICYCLE_JUMP_EN defined: OP 02 in DECODE goes to JUMP (PCWrite=1, PCSource=10), then FETCH; undefined: JUMP is unreachable and OP 02 is illegal (Fault pulse).

Verification
REQ-039 Reset release, MemReady=1, OP=00: states 0,1,2,7,9,1; RegWrite=1 and RegDst=1 only in state 9.
REQ-040 OP=23 with MemReady low for 3 cycles in MEM_READ: stays in state 4 for 4 cycles, then 5 with MemtoReg=1, no Fault.
REQ-041 OP=05: BRANCH has BranchEn=1, BranchType=0, ALUOp=001, PCSource=01; OP=04 gives BranchType=1.
REQ-042 OP=3F: Fault=1 for one cycle in DECODE, next State=1; OP=02 behaves the same without MULTICYCLE_JUMP_EN, and gives JUMP with PCSource=10 with it.
REQ-043 MemReady held 0 in FETCH, WAIT_MAX=15: Fault pulses after 16 cycles in state 1; reset=0 asserted mid-MEM_WRITE clears outputs immediately, without waiting for clk.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: Moore-decoded datapath controls from a 12-state FSM.
// Latency: R/I-type 4 cycles, lw 5, sw 4, branch 3 (zero memory wait); controls valid in the current state's cycle.
// Backpressure: memory stalls via MemReady in FETCH/MEM_READ/MEM_WRITE, bounded by WAIT_MAX before a Fault pulse.
//
// Ports:
//   clk, reset (async, active-low) ; OP[5:0] opcode sampled in DECODE ; MemReady memory handshake
//   PCWrite, BranchEn, BranchType, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUOp[2:0] datapath controls ; State[3:0] debug ; Fault pulse
// Optional feature: define MULTICYCLE_JUMP_EN to decode OP 02 as a jump (JUMP state); otherwise OP 02 is illegal.

module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       BranchEn,
    output logic       BranchType,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] State,
    output logic       Fault
);

    typedef enum logic [3:0] {
        S_START     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    // Instruction class captured in DECODE; later states only look at this,
    // so OP is free to change once the instruction has been decoded.
    typedef enum logic [3:0] {
        C_NONE = 4'd0,
        C_R    = 4'd1,
        C_ADDI = 4'd2,
        C_ANDI = 4'd3,
        C_ORI  = 4'd4,
        C_LUI  = 4'd5,
        C_LW   = 4'd6,
        C_SW   = 4'd7,
        C_BEQ  = 4'd8,
        C_BNE  = 4'd9,
        C_J    = 4'd10
    } cls_t;

    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_R   = 3'b111;
    localparam logic [2:0] ALU_LUI = 3'b000;

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    state_t        state, state_nx;
    cls_t          cls, cls_nx;
    cls_t          op_cls;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout;

    // ALU function for immediate-class instructions.
    function automatic logic [2:0] imm_alu(input cls_t c);
        logic [2:0] r;
        r = ALU_ADD;
        case (c)
            C_ANDI:  r = ALU_AND;
            C_ORI:   r = ALU_OR;
            C_LUI:   r = ALU_LUI;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    // Opcode classification; anything not listed is illegal (C_NONE).
    always_comb begin
        op_cls = C_NONE;
        case (OP)
            6'h00: op_cls = C_R;
            6'h08: op_cls = C_ADDI;
            6'h0C: op_cls = C_ANDI;
            6'h0D: op_cls = C_ORI;
            6'h0F: op_cls = C_LUI;
            6'h23: op_cls = C_LW;
            6'h2B: op_cls = C_SW;
            6'h04: op_cls = C_BEQ;
            6'h05: op_cls = C_BNE;
`ifdef MULTICYCLE_JUMP_EN
            6'h02: op_cls = C_J;
`endif
            default: op_cls = C_NONE;
        endcase
    end

    // States that wait on the memory handshake share one bounded counter.
    assign waiting = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout = waiting && !MemReady && (wait_cnt == CW'(WAIT_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_START;
            cls   <= C_NONE;
        end else begin
            state <= state_nx;
            cls   <= cls_nx;
        end
    end

    // Cleared on any state change and on timeout (timeout from FETCH re-enters
    // FETCH without a state change), so every wait starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state_nx != state) || timeout) begin
            wait_cnt <= '0;
        end else if (waiting && !MemReady) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        cls_nx     = cls;
        PCWrite    = 1'b0;
        BranchEn   = 1'b0;
        BranchType = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUOp      = 3'b000;
        Fault      = 1'b0;

        case (state)
            S_START: begin
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                if (MemReady) begin
                    // Instruction and PC+4 are only committed when memory delivers.
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    state_nx = S_DECODE;
                end else if (timeout) begin
                    Fault    = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_ADD;
                cls_nx  = op_cls;
                case (op_cls)
                    C_R:                             state_nx = S_R_EXEC;
                    C_ADDI, C_ANDI, C_ORI, C_LUI:    state_nx = S_I_EXEC;
                    C_LW, C_SW:                      state_nx = S_MEM_ADDR;
                    C_BEQ, C_BNE:                    state_nx = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    C_J:                             state_nx = S_JUMP;
`endif
                    default: begin
                        Fault    = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = ALU_ADD;
                state_nx = (cls == C_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    state_nx = S_MEM_WB;
                end else if (timeout) begin
                    Fault    = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_nx = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    state_nx = S_FETCH;
                end else if (timeout) begin
                    Fault    = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b00;
                ALUOp    = ALU_R;
                state_nx = S_ALU_WB;
            end
            S_I_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = imm_alu(cls);
                state_nx = S_ALU_WB;
            end
            S_ALU_WB: begin
                // ALUOp stays asserted so ALUOut-derived controls are stable during write-back.
                RegWrite = 1'b1;
                RegDst   = (cls == C_R);
                ALUOp    = (cls == C_R) ? ALU_R : imm_alu(cls);
                state_nx = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = ALU_SUB;
                PCSource   = 2'b01;
                BranchEn   = 1'b1;
                BranchType = (cls == C_BEQ);
                state_nx   = S_FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_nx = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings (and JUMP when jumps are disabled) recover to FETCH.
                state_nx = S_FETCH;
            end
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       MemReady;
    logic       PCWrite, BranchEn, BranchType, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Fault;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
        .PCWrite(PCWrite), .BranchEn(BranchEn), .BranchType(BranchType), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .State(State), .Fault(Fault)
    );

    typedef struct packed {
        logic       pcw, ben, btype, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic [3:0] st;
        logic       flt;
    } ctl_t;

    ctl_t  act;
    ctl_t  exp_q[$];
    string nm_q[$];
    int    checks   = 0;
    int    failures = 0;

    assign act = {PCWrite, BranchEn, BranchType, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, State, Fault};

    // Immediate-op ALU codes: ADDI add, ANDI and, ORI or, LUI lui.
    function automatic logic [2:0] iop(input logic [5:0] op);
        logic [2:0] r;
        case (op)
            6'h0C:   r = 3'b110;
            6'h0D:   r = 3'b101;
            6'h0F:   r = 3'b000;
            default: r = 3'b100;
        endcase
        return r;
    endfunction

    // Control table per state, written from the controller's output definition.
    function automatic ctl_t ref_out(input logic [3:0] st, input logic mr,
                                     input logic [5:0] op, input logic flt);
        ctl_t r;
        r     = '0;
        r.st  = st;
        r.flt = flt;
        case (st)
            4'd1:  begin r.mrd = 1; r.srcb = 2'b01; r.aluop = 3'b100; r.irw = mr; r.pcw = mr; end
            4'd2:  begin r.srcb = 2'b11; r.aluop = 3'b100; end
            4'd3:  begin r.srca = 1; r.srcb = 2'b10; r.aluop = 3'b100; end
            4'd4:  begin r.mrd = 1; r.iord = 1; end
            4'd5:  begin r.rwr = 1; r.m2r = 1; end
            4'd6:  begin r.mwr = 1; r.iord = 1; end
            4'd7:  begin r.srca = 1; r.srcb = 2'b00; r.aluop = 3'b111; end
            4'd8:  begin r.srca = 1; r.srcb = 2'b10; r.aluop = iop(op); end
            4'd9:  begin r.rwr = 1; r.rdst = (op == 6'h00);
                         r.aluop = (op == 6'h00) ? 3'b111 : iop(op); end
            4'd10: begin r.srca = 1; r.aluop = 3'b001; r.pcsrc = 2'b01; r.ben = 1;
                         r.btype = (op == 6'h04); end
            4'd11: begin r.pcw = 1; r.pcsrc = 2'b10; end
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        ctl_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %h (state %0d fault %0b) expected %h (state %0d fault %0b)",
                         n, act, act.st, act.flt, e, e.st, e.flt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Called just after a rising edge: drive inputs for this cycle and queue its expectation.
    task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic flt, input string nm);
        OP       = op;
        MemReady = mr;
        exp_q.push_back(ref_out(st, mr, op, flt));
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic run_rtype(input string nm);
        cyc(6'h00, 1'b1, 4'd1, 1'b0, {nm, "_fetch"});
        cyc(6'h00, 1'b1, 4'd2, 1'b0, {nm, "_decode"});
        cyc(6'h00, 1'b1, 4'd7, 1'b0, {nm, "_rexec"});
        cyc(6'h00, 1'b1, 4'd9, 1'b0, {nm, "_aluwb"});
    endtask

    logic [5:0] iops [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};

    initial begin
        reset    = 1'b0;
        OP       = 6'h00;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        cyc(6'h00, 1'b1, 4'd0, 1'b0, "in_reset_a");
        cyc(6'h00, 1'b1, 4'd0, 1'b0, "in_reset_b");

        // R-type from reset: 0,1,2,7,9,1
        reset = 1'b1;
        cyc(6'h00, 1'b1, 4'd0, 1'b0, "start");
        run_rtype("r");

        // I-types: ADDI, ANDI, ORI, LUI
        foreach (iops[k]) begin
            cyc(iops[k], 1'b1, 4'd1, 1'b0, "i_fetch");
            cyc(iops[k], 1'b1, 4'd2, 1'b0, "i_decode");
            cyc(iops[k], 1'b1, 4'd8, 1'b0, "i_exec");
            cyc(iops[k], 1'b1, 4'd9, 1'b0, "i_aluwb");
        end

        // lw with three wait cycles in MEM_READ
        cyc(6'h23, 1'b1, 4'd1, 1'b0, "lw_fetch");
        cyc(6'h23, 1'b1, 4'd2, 1'b0, "lw_decode");
        cyc(6'h23, 1'b1, 4'd3, 1'b0, "lw_addr");
        cyc(6'h23, 1'b0, 4'd4, 1'b0, "lw_wait1");
        cyc(6'h23, 1'b0, 4'd4, 1'b0, "lw_wait2");
        cyc(6'h23, 1'b0, 4'd4, 1'b0, "lw_wait3");
        cyc(6'h23, 1'b1, 4'd4, 1'b0, "lw_ready");
        cyc(6'h23, 1'b1, 4'd5, 1'b0, "lw_wb");

        // sw, zero wait
        cyc(6'h2B, 1'b1, 4'd1, 1'b0, "sw_fetch");
        cyc(6'h2B, 1'b1, 4'd2, 1'b0, "sw_decode");
        cyc(6'h2B, 1'b1, 4'd3, 1'b0, "sw_addr");
        cyc(6'h2B, 1'b1, 4'd6, 1'b0, "sw_write");

        // beq / bne
        cyc(6'h04, 1'b1, 4'd1, 1'b0, "beq_fetch");
        cyc(6'h04, 1'b1, 4'd2, 1'b0, "beq_decode");
        cyc(6'h04, 1'b1, 4'd10, 1'b0, "beq_branch");
        cyc(6'h05, 1'b1, 4'd1, 1'b0, "bne_fetch");
        cyc(6'h05, 1'b1, 4'd2, 1'b0, "bne_decode");
        cyc(6'h05, 1'b1, 4'd10, 1'b0, "bne_branch");

        // Illegal opcode: fault in DECODE, back to FETCH
        cyc(6'h3F, 1'b1, 4'd1, 1'b0, "ill_fetch");
        cyc(6'h3F, 1'b1, 4'd2, 1'b1, "ill_decode_fault");

        // OP 02: jump when enabled, illegal otherwise
        cyc(6'h02, 1'b1, 4'd1, 1'b0, "j_fetch");
`ifdef MULTICYCLE_JUMP_EN
        cyc(6'h02, 1'b1, 4'd2, 1'b0, "j_decode");
        cyc(6'h02, 1'b1, 4'd11, 1'b0, "j_jump");
`else
        cyc(6'h02, 1'b1, 4'd2, 1'b1, "j_decode_fault");
`endif

        // FETCH timeout: 15 quiet cycles, fault on the 16th, then recover
        for (int i = 0; i < 15; i++) cyc(6'h00, 1'b0, 4'd1, 1'b0, "fetch_wait");
        cyc(6'h00, 1'b0, 4'd1, 1'b1, "fetch_timeout");
        run_rtype("after_to");

        // Async reset in the middle of a stalled MEM_WRITE
        cyc(6'h2B, 1'b1, 4'd1, 1'b0, "asw_fetch");
        cyc(6'h2B, 1'b1, 4'd2, 1'b0, "asw_decode");
        cyc(6'h2B, 1'b1, 4'd3, 1'b0, "asw_addr");
        cyc(6'h2B, 1'b0, 4'd6, 1'b0, "asw_wait1");
        MemReady = 1'b0;
        #1;
        chk("asw_still_waiting_state", {28'd0, State}, 32'd6);
        chk("asw_memwrite_before_reset", {31'd0, MemWrite}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_state", {28'd0, State}, 32'd0);
        chk("async_reset_outputs", {9'd0, act}, 32'd0);
        @(posedge clk);
        #1;
        cyc(6'h2B, 1'b0, 4'd0, 1'b0, "held_reset");
        reset = 1'b1;
        cyc(6'h00, 1'b1, 4'd0, 1'b0, "restart");
        run_rtype("after_rst");

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
